// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory read responder.
// Holds the bus widths and the storage depth. It defines the word type and
// the {valid,data} record that travels down the read-latency pipe. It also
// provides the byte-address to word-index helper.
package mem_pkg;

  localparam int DATA_W          = 16;  // data word width
  localparam int ADDR_W          = 16;  // request byte-address width
  localparam int MEM_AW          = 13;  // word-index bits stored (2^MEM_AW words)
  localparam int DEFAULT_LATENCY = 4;   // read latency in cycles (legal 1..8)
  localparam int CNT_W           = 4;   // width of the outstanding-read counter

  typedef logic [DATA_W-1:0] mem_word_t;

  typedef struct packed {
    logic      valid;
    mem_word_t data;
  } pipe_stage_t;

  // addr[0] selects a byte within the word and is ignored. Bits above MEM_AW
  // wrap silently, so aliased addresses hit the same word.
  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[MEM_AW:1];
  endfunction

endpackage

// File: rtl/mem_read_responder_if.sv
// Request/response bus between the cache-fill arbiter (master) and the
// memory responder (slave).
//   enable      master->slave  request valid this cycle
//   wr          master->slave  1 = write, 0 = read
//   addr        master->slave  byte address
//   data_in     master->slave  write data
//   data_out    slave->master  read data (meaningful when data_valid=1)
//   data_valid  slave->master  read data returning this cycle
//   outstanding slave->master  reads accepted but not yet returned
interface mem_read_responder_if;
  import mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  mem_word_t         data_in;
  mem_word_t         data_out;
  logic              data_valid;
  logic [CNT_W-1:0]  outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding
  );

endinterface

// File: rtl/mem_delay_pipe.sv
// Fixed-latency shift register of {valid,data} records. It advances every
// cycle. A stage only takes new data when the incoming record is valid, so
// the last stage holds its previous data through idle cycles.
//   clk       clock
//   rst       synchronous active-high clear of every stage
//   in_stage  record entering stage 1
//   out_stage record leaving the last stage (registered)
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  pipe_stage_t in_stage,
  output pipe_stage_t out_stage
);

  pipe_stage_t stages [LATENCY];

  // Shift the valid flags unconditionally and carry data only with a valid record.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0].valid <= in_stage.valid;
      if (in_stage.valid) begin
        stages[0].data <= in_stage.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stages[i].valid <= stages[i-1].valid;
        if (stages[i-1].valid) begin
          stages[i].data <= stages[i-1].data;
        end
      end
    end
  end

  assign out_stage = stages[LATENCY-1];

endmodule

// File: rtl/mem_read_responder.sv
// Main-memory model that answers cache-fill word requests. It accepts one
// request per cycle and never back-pressures. A write commits at the
// accepting edge. A read samples the array at the accepting edge and returns
// the data exactly LATENCY cycles later, in order. The array itself is never
// reset, and its power-up contents are undefined.
//   clk  clock, all state on the rising edge
//   rst  synchronous active-high reset (clears pipe, outputs, counter)
//   bus  slave side of mem_read_responder_if
module mem_read_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input logic                 clk,
  input logic                 rst,
  mem_read_responder_if.slave bus
);

  mem_word_t         mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              rd_acc;
  logic              wr_acc;
  pipe_stage_t       rd_stage;
  pipe_stage_t       out_stage;
  logic [CNT_W-1:0]  outstanding_cnt;
  logic              unused_addr_bits;

  assign idx    = word_idx(bus.addr);
  // Requests presented while rst is high are dropped, writes included.
  assign rd_acc = bus.enable & ~bus.wr & ~rst;
  assign wr_acc = bus.enable &  bus.wr & ~rst;

  // Byte-select and aliased high address bits carry no meaning here.
  assign unused_addr_bits = ^{bus.addr[ADDR_W-1:MEM_AW+1], bus.addr[0]};

  // Write port: commit at the accepting edge.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= bus.data_in;
    end
  end

  // The array is read combinationally and captured into stage 1 at the
  // accepting edge. A write on the previous edge is therefore visible, and a
  // later write cannot disturb a read that has already been captured.
  assign rd_stage = '{valid: rd_acc, data: mem[idx]};

  mem_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_stage  (rd_stage),
    .out_stage (out_stage)
  );

  // Outstanding reads: +1 on accept, -1 when a response leaves. A read that
  // is accepted on the same edge as a response leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_cnt <= 4'd0;
    end else begin
      outstanding_cnt <= outstanding_cnt + {3'b000, rd_acc} - {3'b000, out_stage.valid};
    end
  end

  assign bus.data_out    = out_stage.data;
  assign bus.data_valid  = out_stage.valid;
  assign bus.outstanding = outstanding_cnt;

endmodule

// File: tb/tb_mem_read_responder.sv
// Self-checking bench for mem_read_responder with LATENCY=4. A table of
// request records carries each read's expected word. A scoreboard queue
// holds {due cycle, data} for every read accepted. At every falling edge the
// bench checks data_valid, data_out (or its held value) and outstanding
// against the queue.
module tb_mem_read_responder;
  import mem_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_read_responder_if bus();

  mem_read_responder #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  vec_t        vecs[$];
  resp_t       sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Compare DUT outputs against the scoreboard for the current cycle.
  task automatic sample();
    logic  ev;
    resp_t r;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("outstanding", 32'(bus.outstanding), 32'(sb.size()));
    chk("outstanding_le_latency", 32'(bus.outstanding <= 4'(LAT)), 32'd1);
    chk("data_valid", 32'(bus.data_valid), 32'(ev));
    if (ev) begin
      r = sb.pop_front();
      chk("data_out", 32'(bus.data_out), 32'(r.data));
      last_data = r.data;
    end else begin
      chk("data_out_hold", 32'(bus.data_out), 32'(last_data));
    end
  endtask

  // One cycle: check outputs, then drive the request for the next edge.
  task automatic step(input logic r, input logic en, input logic w,
                      input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    @(negedge clk);
    sample();
    rst            = r;
    bus.enable     = en;
    bus.wr         = w;
    bus.addr       = a;
    bus.data_in    = d;
    if (r) begin
      sb.delete();
      last_data = 16'h0000;
    end else if (en && !w) begin
      sb.push_back('{due: cyc + LAT, data: e});
    end
  endtask

  function automatic void add(input logic en, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] e);
    vecs.push_back('{en: en, wr: w, addr: a, din: d, exp: e});
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endfunction

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;
    last_data   = 16'h0000;

    // Aliasing and addr[0]: 0x0001, 0x0000 and 0x4000 all map to word 0.
    add(1'b1, 1'b1, 16'h0001, 16'h1111, 16'h0000);
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111);
    add(1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1111);
    idle(5);
    // Single read of word 0x0010 via byte address 0x0020.
    add(1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000);
    idle(4);
    add(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF);
    idle(5);
    // Write-then-read and read-then-write on the same word.
    add(1'b1, 1'b1, 16'h0040, 16'hA5A5, 16'h0000);
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5A5);
    add(1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h0000);
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A);
    idle(5);
    // Block fill: preload 8 words, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 16'(16'h1230 + 2*i), 16'(16'hC000 + i), 16'h0000);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 16'(16'h1230 + 2*i), 16'h0000, 16'(16'hC000 + i));
    idle(6);
    // Gapped stream: read, idle, read, idle, idle, read.
    add(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF);
    idle(1);
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A);
    idle(2);
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111);
    idle(6);

    // Two cycles of reset to get a clean start.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data_valid", 32'(bus.data_valid), 32'd0);
    chk("reset_outstanding", 32'(bus.outstanding), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp);
    end

    // Mid-stream reset: two reads in flight, and a write presented during the
    // reset cycle must be ignored.
    step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A);
    step(1'b1, 1'b1, 1'b1, 16'h0000, 16'hDEAD, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("midreset_data_valid", 32'(bus.data_valid), 32'd0);
    chk("midreset_outstanding", 32'(bus.outstanding), 32'd0);
    chk("midreset_data_out", 32'(bus.data_out), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    @(negedge clk);
    sample();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
